// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used at request acceptance.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // An access is misaligned when the byte offset is not a multiple of 2^size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      SIZE_H:  return offset[0];
      SIZE_W:  return |offset[1:0];
      SIZE_D:  return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and byte-lane merge of
// store data into the current memory word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic [BITS-1:0] word,
  input  logic [BITS-1:0] wdata,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [BITS-1:0] rdata,
  output logic [BITS-1:0] merged
);

  logic [5:0]      shamt;
  logic [BITS-1:0] lane;
  logic [BITS-1:0] mask;
  logic [BITS-1:0] lane_mask;

  always_comb begin
    shamt = {offset, 3'b000};
    lane  = word >> shamt;
    mask  = '1;
    rdata = lane;
    case (size)
      SIZE_B: begin
        mask  = {{(BITS-8){1'b0}}, 8'hFF};
        rdata = {{(BITS-8){~is_unsigned & lane[7]}}, lane[7:0]};
      end
      SIZE_H: begin
        mask  = {{(BITS-16){1'b0}}, 16'hFFFF};
        rdata = {{(BITS-16){~is_unsigned & lane[15]}}, lane[15:0]};
      end
      SIZE_W: begin
        mask  = {{(BITS-32){1'b0}}, 32'hFFFF_FFFF};
        rdata = {{(BITS-32){~is_unsigned & lane[31]}}, lane[31:0]};
      end
      default: begin
        mask  = '1;
        rdata = lane;
      end
    endcase
    // Only the addressed bytes take store data; the rest keep the memory value.
    lane_mask = mask << shamt;
    merged    = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store at a time, drives a word-indexed
// memory from registered state, and returns a one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int BITS      = 64,
  parameter  int DEPTH     = 32,
  localparam int ADDR_BITS = $clog2(DEPTH*BITS/8),
  localparam int IDX_BITS  = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [BITS-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [BITS-1:0]      rsp_rdata,
  output logic [IDX_BITS-1:0]  mem_endr,
  output logic                 mem_we,
  output logic [BITS-1:0]      mem_din,
  input  logic [BITS-1:0]      mem_dout,
  output state_t               dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // rsp_valid is a single-cycle pulse that the requester must take (no backpressure).

  state_t                 state, state_next;
  logic                   we_q, uns_q, err_q;
  logic [1:0]             size_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [BITS-1:0]        wdata_q, rdata_q, merge_q;
  logic [BITS-1:0]        ext_rdata, merged;
  logic                   accept, req_misaligned, store_full;

  assign accept         = req_valid && (state == IDLE);
  assign req_misaligned = misaligned(req_size, req_addr[2:0]);
  assign store_full     = we_q && (size_q == SIZE_D);

  lsu_align #(.BITS(BITS)) u_align (
    .word        (mem_dout),
    .wdata       (wdata_q),
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (ext_rdata),
    .merged      (merged)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_misaligned ? RESP : ACCESS;
      ACCESS:  state_next = (we_q && !store_full) ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_misaligned;
        rdata_q <= '0;
      end
      if (state == ACCESS && !we_q) rdata_q <= ext_rdata;
      if (state == ACCESS && we_q && !store_full) merge_q <= merged;
    end
  end

  // Memory and response outputs are decoded from registers only.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && err_q;
    rsp_rdata = (state == RESP) ? rdata_q : '0;
    mem_endr  = addr_q[ADDR_BITS-1:3];
    mem_we    = ((state == ACCESS) && store_full) || (state == WRITE);
    mem_din   = '0;
    if (state == WRITE) mem_din = merge_q;
    else if ((state == ACCESS) && store_full) mem_din = wdata_q;
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory, directed cases from the
// description, randomized mixed traffic, back-to-back issue and reset mid-store.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int BITS  = 64;
  localparam int DEPTH = 32;
  localparam int AB    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic [AB-1:0]     req_addr = '0;
  logic [BITS-1:0]   req_wdata = '0;
  logic              req_ready, rsp_valid, rsp_err, mem_we;
  logic [BITS-1:0]   rsp_rdata, mem_din, mem_dout;
  logic [4:0]        mem_endr;
  state_t            dbg_state;

  logic [BITS-1:0]   mem [DEPTH];
  logic [7:0]        ref_bytes [DEPTH*8];
  logic [BITS-1:0]   exp_q [$];
  logic              load_mem = 1'b0;
  int                errors = 0;
  int                checks = 0;
  int                we_pulses = 0;
  int                rsp_pulses = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_endr(mem_endr),
    .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_bytes[idx*8 + b];
    return w;
  endfunction

  function automatic logic [63:0] ref_load(input logic [7:0] addr, input logic [1:0] size, input logic uns);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_bytes[int'(addr) + i]) << (8*i));
    if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  // Data memory: combinational read, synchronous write; preloaded from the model.
  assign mem_dout = mem[mem_endr];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_word(i);
    end else if (mem_we) begin
      mem[mem_endr] <= mem_din;
    end
    if (mem_we) we_pulses++;
    if (rsp_valid) rsp_pulses++;
  end

  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [7:0] addr, input logic [63:0] wdata,
                        input logic hold, output logic [63:0] got_rdata, output int got_lat);
    int n, lat, exp_lat, we0, exp_we;
    logic exp_err;
    logic [63:0] exp_rdata;
    n = 1 << size;
    exp_err = (int'(addr) % n) != 0;
    exp_lat = exp_err ? 1 : ((we && size != 2'b11) ? 3 : 2);
    exp_we = (we && !exp_err) ? 1 : 0;
    exp_q.push_back((exp_err || we) ? 64'd0 : ref_load(addr, size, uns));
    if (we && !exp_err)
      for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    we0 = we_pulses;
    @(posedge clk); #1;
    if (!hold) begin
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = 8'($urandom); req_wdata = {$urandom, $urandom};
    end
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    got_lat = lat;
    got_rdata = rsp_rdata;
    exp_rdata = exp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL %s rsp_timeout: no rsp_valid within %0d cycles", name, lat);
    end else begin
      checks++;
      if (lat != exp_lat) begin
        errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (rsp_err !== exp_err) begin
        errors++; $display("FAIL %s rsp_err: got %b want %b", name, rsp_err, exp_err);
      end
      checks++;
      if (rsp_rdata !== exp_rdata) begin
        errors++; $display("FAIL %s rsp_rdata: got %h want %h", name, rsp_rdata, exp_rdata);
      end
      checks++;
      if (req_ready !== 1'b0) begin
        errors++; $display("FAIL %s ready_in_resp: got %b want 0", name, req_ready);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s rsp_one_cycle: rsp_valid still %b", name, rsp_valid);
    end
    checks++;
    if (we_pulses - we0 != exp_we) begin
      errors++; $display("FAIL %s mem_we_count: got %0d want %0d", name, we_pulses - we0, exp_we);
    end
    checks++;
    if (mem[addr[7:3]] !== ref_word(int'(addr[7:3]))) begin
      errors++; $display("FAIL %s mem_word: got %h want %h", name, mem[addr[7:3]], ref_word(int'(addr[7:3])));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
      errors++; $display("FAIL %s ctrl: got rdy/vld/err/we=%b want 1000", name, {req_ready, rsp_valid, rsp_err, mem_we});
    end
    checks++;
    if (rsp_rdata !== 64'd0 || mem_din !== 64'd0 || mem_endr !== 5'd0) begin
      errors++; $display("FAIL %s data: got rdata=%h din=%h endr=%0d want 0", name, rsp_rdata, mem_din, mem_endr);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL %s state: got %0d want IDLE", name, dbg_state);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH*8; i++) ref_bytes[i] = 8'($urandom);
    load_mem = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk);
    load_mem = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [63:0] rd;
    int lat;
    do_req("st_d", 1'b1, SIZE_D, 1'b0, 8'h08, 64'h1122334455667788, 1'b0, rd, lat);
    checks++;
    if (mem[1] !== 64'h1122334455667788 || lat != 2) begin
      errors++; $display("FAIL st_d_literal: got word1=%h lat=%0d want 1122334455667788 lat 2", mem[1], lat);
    end
    do_req("st_d88", 1'b1, SIZE_D, 1'b0, 8'h08, 64'h8800000000000000, 1'b0, rd, lat);
    do_req("ld_b_s", 1'b0, SIZE_B, 1'b0, 8'h0F, 64'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFF88) begin
      errors++; $display("FAIL ld_b_signed_literal: got %h want ffffffffffffff88", rd);
    end
    do_req("ld_b_u", 1'b0, SIZE_B, 1'b1, 8'h0F, 64'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 64'h0000000000000088) begin
      errors++; $display("FAIL ld_b_unsigned_literal: got %h want 0000000000000088", rd);
    end
    do_req("st_d2", 1'b1, SIZE_D, 1'b0, 8'h08, 64'h1122334455667788, 1'b0, rd, lat);
    do_req("st_h", 1'b1, SIZE_H, 1'b0, 8'h0A, 64'h000000000000BEEF, 1'b0, rd, lat);
    checks++;
    if (mem[1] !== 64'h11223344BEEF7788 || lat != 3) begin
      errors++; $display("FAIL st_h_literal: got word1=%h lat=%0d want 11223344beef7788 lat 3", mem[1], lat);
    end
    do_req("ld_w_mis", 1'b0, SIZE_W, 1'b0, 8'h06, 64'd0, 1'b0, rd, lat);
    checks++;
    if (lat != 1 || rd !== 64'd0) begin
      errors++; $display("FAIL ld_w_mis_literal: got lat=%0d rdata=%h want lat 1 rdata 0", lat, rd);
    end
    do_req("ld_d", 1'b0, SIZE_D, 1'b1, 8'h08, 64'd0, 1'b0, rd, lat);
  endtask

  task automatic test_random();
    logic [63:0] rd;
    int lat, n;
    logic [1:0] size;
    logic [7:0] addr;
    for (int k = 0; k < 150; k++) begin
      size = 2'($urandom_range(0, 3));
      n = 1 << size;
      addr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~8'(n - 1);
      do_req("rand", 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
             {$urandom, $urandom}, 1'b0, rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd;
    int lat;
    logic [7:0] addr;
    for (int k = 0; k < 20; k++) begin
      addr = 8'($urandom_range(0, 255));
      do_req("b2b_st", 1'b1, 2'($urandom_range(0, 2)), 1'b0, addr & 8'hF8, {$urandom, $urandom}, 1'b1, rd, lat);
      do_req("b2b_ld", 1'b0, SIZE_D, 1'b0, addr & 8'hF8, 64'd0, 1'b1, rd, lat);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int r0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_H; req_unsigned = 1'b0;
    req_addr = 8'h1A; req_wdata = {$urandom, $urandom};
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b1 || dbg_state !== WRITE) begin
      errors++; $display("FAIL rst_write_reached: got mem_we=%b state=%0d want 1 WRITE", mem_we, dbg_state);
    end
    r0 = rsp_pulses;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem[3] !== ref_word(3)) begin
      errors++; $display("FAIL rst_mem_unchanged: got %h want %h", mem[3], ref_word(3));
    end
    checks++;
    if (rsp_pulses != r0 || req_ready !== 1'b1 || dbg_state !== IDLE) begin
      errors++; $display("FAIL rst_no_rsp: got rsp=%0d ready=%b state=%0d want 0 1 IDLE", rsp_pulses - r0, req_ready, dbg_state);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
